// File: rtl/serial_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM state encoding,
// frame geometry and the clock-to-baud divisor helper.
package serial_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int START_BITS = 1;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

    // Rounded integer division: clocks per bit for a given clock and baud rate.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; the reset value
// is a parameter so an idle-high line can come out of reset as 1.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_uart_rx.sv
// 8N1 UART receiver: synchronizes the line, centres on each bit with a
// down-counter, and hands bytes out through a one-deep valid/ready holding register.
module serial_uart_rx
    import serial_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int DIV         = baud_div(CLK_FREQ_HZ, BAUD)
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    logic line_s;
    logic line_prev_q;
    logic fall_edge;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic sample_tick;
    logic byte_done;
    logic stop_bad;
    logic load_byte;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d_i   (serial_rx),
        .q_o   (line_s)
    );

    // Edge-detect register also resets high so reset release never looks like a start bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            line_prev_q <= 1'b1;
        end else begin
            line_prev_q <= line_s;
        end
    end

    assign fall_edge   = line_prev_q & ~line_s;
    assign sample_tick = (cnt_q == '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            RX_IDLE: begin
                if (fall_edge) begin
                    state_d = RX_START;
                    cnt_d   = CNT_HALF;
                end
            end

            RX_START: begin
                if (sample_tick) begin
                    if (!line_s) begin
                        state_d = RX_DATA;
                        cnt_d   = CNT_RELOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RX_DATA: begin
                if (sample_tick) begin
                    shift_d[idx_q] = line_s;
                    cnt_d          = CNT_RELOAD;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            RX_STOP: begin
                if (sample_tick) begin
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_done = (state_q == RX_STOP) && sample_tick &&  line_s;
    assign stop_bad  = (state_q == RX_STOP) && sample_tick && !line_s;

    // A held byte may be replaced in the same cycle the consumer takes it.
    assign load_byte = byte_done && (!rx_valid_q || rx_ready);

    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = stop_bad;
        overrun_d   = byte_done && rx_valid_q && !rx_ready;

        if (load_byte) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // NOTE: the shift register is reset along with the rest; it is a handful of
    // flops, not a memory array, so a defined post-reset value costs nothing.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_serial_uart_rx.sv
// Directed bench for serial_uart_rx at 10 clocks per bit: clean frames,
// glitch rejection, framing error, overrun, mid-frame reset and a 256-byte burst.
module tb_serial_uart_rx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = 10;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       serial_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];
    int valid_cycles = 0;
    int fe_cnt       = 0;
    int ov_cnt       = 0;
    int busy_cycles  = 0;

    int q_base, v_base, fe_base, ov_base, b_base;

    serial_uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD),
        .DIV         (DIV)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .serial_rx (serial_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Observe on the falling edge, away from the active edge.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (rx_valid)             valid_cycles++;
            if (rx_valid && rx_ready) rx_q.push_back(rx_data);
            if (frame_err)            fe_cnt++;
            if (overrun)              ov_cnt++;
            if (busy)                 busy_cycles++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serial_rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            idle(DIV);
        end
        serial_rx = stop_bit;
        idle(DIV);
        serial_rx = 1'b1;
    endtask

    task automatic snapshot();
        q_base  = rx_q.size();
        v_base  = valid_cycles;
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        b_base  = busy_cycles;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        serial_rx = 1'b1;
        rx_ready  = 1'b1;
        idle(3);

        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_rx_data",   32'(rx_data),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);

        sys_rst_n = 1'b1;
        idle(5);

        // Clean byte, consumer always ready: exactly one valid cycle.
        snapshot();
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_count",   32'(rx_q.size() - q_base), 32'd1);
        if (rx_q.size() > q_base) check("a5_data", 32'(rx_q[q_base]), 32'hA5);
        check("a5_valid_cycles", 32'(valid_cycles - v_base), 32'd1);
        check("a5_frame_err", 32'(fe_cnt - fe_base), 32'd0);
        check("a5_overrun",   32'(ov_cnt - ov_base), 32'd0);

        // Three-cycle low glitch: START entered, then rejected.
        snapshot();
        serial_rx = 1'b0;
        idle(3);
        serial_rx = 1'b1;
        idle(30);
        check("glitch_busy_seen", 32'(busy_cycles > b_base), 32'd1);
        check("glitch_busy_now",  32'(busy), 32'd0);
        check("glitch_valid",     32'(valid_cycles - v_base), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt - fe_base), 32'd0);
        check("glitch_overrun",   32'(ov_cnt - ov_base), 32'd0);

        // Stop bit forced low.
        snapshot();
        send_frame(8'h3C, 1'b0);
        idle(20);
        check("ferr_pulses", 32'(fe_cnt - fe_base), 32'd1);
        check("ferr_valid",  32'(valid_cycles - v_base), 32'd0);

        // Consumer stalled across two back-to-back frames.
        rx_ready = 1'b0;
        snapshot();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(20);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_held",  32'(rx_data),  32'h11);
        check("ovr_pulses",     32'(ov_cnt - ov_base), 32'd1);
        rx_ready = 1'b1;
        idle(2);
        check("ovr_valid_clear", 32'(rx_valid), 32'd0);
        check("ovr_drained", 32'(rx_q.size() - q_base), 32'd1);
        if (rx_q.size() > q_base) check("ovr_drained_data", 32'(rx_q[q_base]), 32'h11);

        // Reset during data bit 4 of 0xFF, then a clean 0x5A.
        serial_rx = 1'b0;
        idle(DIV);
        serial_rx = 1'b1;
        idle(4 * DIV + DIV / 2);
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        idle(3);
        check("mid_rst_busy",  32'(busy),     32'd0);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        sys_rst_n = 1'b1;
        idle(20);
        snapshot();
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("mid_count", 32'(rx_q.size() - q_base), 32'd1);
        if (rx_q.size() > q_base) check("mid_data", 32'(rx_q[q_base]), 32'h5A);
        check("mid_frame_err", 32'(fe_cnt - fe_base), 32'd0);

        // 256 back-to-back frames, no idle gap between stop and next start.
        snapshot();
        for (int v = 0; v < 256; v++) begin
            send_frame(8'(v), 1'b1);
        end
        idle(30);
        check("burst_count", 32'(rx_q.size() - q_base), 32'd256);
        for (int v = 0; v < 256; v++) begin
            if (q_base + v < rx_q.size()) begin
                check($sformatf("burst_byte_%0d", v), 32'(rx_q[q_base + v]), 32'(v));
            end
        end
        check("burst_frame_err", 32'(fe_cnt - fe_base), 32'd0);
        check("burst_overrun",   32'(ov_cnt - ov_base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
